// File: rtl/inj_scan_seq_pkg.sv
// Shared types and constants for the injection scan sequencer.
package inj_scan_pkg;

    localparam int CNT_W_DEF      = 16;
    localparam int PIX_W_DEF      = 8;
    localparam int INJ_PERIOD_MIN = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONF      = 3'd1,
        ST_GATE_WAIT = 3'd2,
        ST_INJECT    = 3'd3,
        ST_PERIOD    = 3'd4,
        ST_DRAIN     = 3'd5,
        ST_NEXT      = 3'd6
    } state_t;

endpackage

// File: rtl/inj_scan_seq_if.sv
// Control/status bundle between the scan sequencer (slave) and its controller (master).
interface inj_scan_seq_if
    import inj_scan_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PIX_W = PIX_W_DEF
) ();

    logic             START;
    logic             ABORT;
    logic [PIX_W-1:0] N_PIX;
    logic [CNT_W-1:0] N_INJ;
    logic [CNT_W-1:0] GATE_DLY;
    logic [CNT_W-1:0] INJ_PERIOD;
    logic [CNT_W-1:0] DRAIN_TMO;
    logic             CONF_REQ;
    logic             CONF_ACK;
    logic             RO_BUSY;
    logic [PIX_W-1:0] PIX_IDX;
    logic             GATE;
    logic             INJ;
    logic             RST_GRAY;
    logic             BUSY;
    logic             DONE;
    logic             TMO_ERR;

    modport master (
        output START, ABORT, N_PIX, N_INJ, GATE_DLY, INJ_PERIOD, DRAIN_TMO,
               CONF_ACK, RO_BUSY,
        input  CONF_REQ, PIX_IDX, GATE, INJ, RST_GRAY, BUSY, DONE, TMO_ERR
    );

    modport slave (
        input  START, ABORT, N_PIX, N_INJ, GATE_DLY, INJ_PERIOD, DRAIN_TMO,
               CONF_ACK, RO_BUSY,
        output CONF_REQ, PIX_IDX, GATE, INJ, RST_GRAY, BUSY, DONE, TMO_ERR
    );

endinterface

// File: rtl/inj_scan_seq_timer.sv
// Loadable saturating down-counter with zero flag; one instance is shared by all timed states.
module seq_timer #(
    parameter int W = 16
) (
    input  logic         CLK40,
    input  logic         nRST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/inj_scan_seq.sv
// Pixel injection scan sequencer: per pixel configure, gate, inject N times, drain readout.
// Optional RST_GRAY pulse on gate opening is built only with INJ_SCAN_SEQ_GRAY_RST_EN defined.
//
// state        | meaning
// ST_IDLE      | waiting for START
// ST_CONF      | CONF_REQ high until CONF_ACK
// ST_GATE_WAIT | GATE open, waiting GATE_DLY before first injection
// ST_INJECT    | single-cycle INJ pulse
// ST_PERIOD    | spacing until next injection or end of pixel
// ST_DRAIN     | GATE closed, waiting for RO_BUSY low or timeout
// ST_NEXT      | advance pixel or finish scan
module inj_scan_seq
    import inj_scan_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input logic           CLK40,
    input logic           nRST,
    inj_scan_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(INJ_PERIOD_MIN);

    state_t           state, next_state;
    logic [PIX_W-1:0] n_pix_q, pix_q;
    logic [CNT_W-1:0] n_inj_q, gate_dly_q, period_q, drain_tmo_q, inj_cnt;
    logic             tmo_err_q, done_q;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_val;
    logic             start_scan, inc_inj, adv_pix, set_tmo, set_done;

    seq_timer #(.W(CNT_W)) u_timer (
        .CLK40    (CLK40),
        .nRST     (nRST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Timer loads hold duration-1 because the zero cycle itself is the last cycle of the state.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_dec    = 1'b0;
        start_scan = 1'b0;
        inc_inj    = 1'b0;
        adv_pix    = 1'b0;
        set_tmo    = 1'b0;
        set_done   = 1'b0;
        if ((state != ST_IDLE) && bus.ABORT) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.START && !bus.ABORT) begin
                        if (bus.N_PIX != '0) begin
                            start_scan = 1'b1;
                            next_state = ST_CONF;
                        end else begin
                            set_done = 1'b1;
                        end
                    end
                end
                ST_CONF: begin
                    if (bus.CONF_ACK) begin
                        next_state = ST_GATE_WAIT;
                        tmr_load   = 1'b1;
                        tmr_val    = (gate_dly_q == '0) ? '0 : gate_dly_q - ONE;
                    end
                end
                ST_GATE_WAIT: begin
                    if (tmr_zero) next_state = ST_INJECT;
                    else          tmr_dec    = 1'b1;
                end
                ST_INJECT: begin
                    inc_inj    = 1'b1;
                    next_state = ST_PERIOD;
                    tmr_load   = 1'b1;
                    tmr_val    = period_q - PER_MIN;
                end
                ST_PERIOD: begin
                    if (!tmr_zero) begin
                        tmr_dec = 1'b1;
                    end else if (inj_cnt < n_inj_q) begin
                        next_state = ST_INJECT;
                    end else begin
                        next_state = ST_DRAIN;
                        tmr_load   = 1'b1;
                        tmr_val    = (drain_tmo_q == '0) ? '0 : drain_tmo_q - ONE;
                    end
                end
                ST_DRAIN: begin
                    if (!bus.RO_BUSY) begin
                        next_state = ST_NEXT;
                    end else if (tmr_zero) begin
                        set_tmo    = 1'b1;
                        next_state = ST_NEXT;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (pix_q == (n_pix_q - PIX_W'(1))) begin
                        set_done   = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        adv_pix    = 1'b1;
                        next_state = ST_CONF;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST) begin
            n_pix_q     <= '0;
            pix_q       <= '0;
            n_inj_q     <= '0;
            gate_dly_q  <= '0;
            period_q    <= '0;
            drain_tmo_q <= '0;
            inj_cnt     <= '0;
            tmo_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= set_done;
            if (start_scan) begin
                n_pix_q     <= bus.N_PIX;
                n_inj_q     <= (bus.N_INJ == '0) ? ONE : bus.N_INJ;
                gate_dly_q  <= bus.GATE_DLY;
                period_q    <= (bus.INJ_PERIOD < PER_MIN) ? PER_MIN : bus.INJ_PERIOD;
                drain_tmo_q <= bus.DRAIN_TMO;
                pix_q       <= '0;
                inj_cnt     <= '0;
                tmo_err_q   <= 1'b0;
            end else begin
                if (inc_inj && (inj_cnt != '1)) inj_cnt <= inj_cnt + ONE;
                if (adv_pix) begin
                    inj_cnt <= '0;
                    if (pix_q != '1) pix_q <= pix_q + PIX_W'(1);
                end
                if (set_tmo) tmo_err_q <= 1'b1;
            end
        end
    end

    assign bus.CONF_REQ = (state == ST_CONF);
    assign bus.GATE     = (state == ST_GATE_WAIT) || (state == ST_INJECT) || (state == ST_PERIOD);
    assign bus.INJ      = (state == ST_INJECT);
    assign bus.BUSY     = (state != ST_IDLE);
    assign bus.DONE     = done_q;
    assign bus.TMO_ERR  = tmo_err_q;
    assign bus.PIX_IDX  = pix_q;

`ifdef INJ_SCAN_SEQ_GRAY_RST_EN
    logic rst_gray_q;

    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST) rst_gray_q <= 1'b0;
        else       rst_gray_q <= (state == ST_CONF) && (next_state == ST_GATE_WAIT);
    end

    assign bus.RST_GRAY = rst_gray_q;
`else
    assign bus.RST_GRAY = 1'b0;
`endif

endmodule

// File: tb/tb_inj_scan_seq.sv
// Randomized scoreboard bench for inj_scan_seq: a timing model predicts every CONF/GATE/INJ/DONE event.
module tb_inj_scan_seq;

    logic CLK40 = 1'b0;
    logic nRST  = 1'b0;

    inj_scan_seq_if bus ();

    inj_scan_seq dut (
        .CLK40 (CLK40),
        .nRST  (nRST),
        .bus   (bus)
    );

    always #5 CLK40 = ~CLK40;

    typedef enum int {EV_CONF, EV_GRISE, EV_INJ, EV_GFALL, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       t;
        int       pix;
    } ev_t;

    ev_t exp_q[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  ack_dly  = 1;
    int  busy_len = 0;
    bit  mon_en   = 1'b0;
    bit  exp_tmo  = 1'b0;

    always @(posedge CLK40) cyc <= cyc + 1;

    task automatic check_val(input string name, input longint got, input longint req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic check_ev(input ev_kind_t k);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %s at cycle %0d, required none", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if ((e.kind != k) || (e.t != cyc) || ((e.pix >= 0) && (e.pix != int'(bus.PIX_IDX)))) begin
                n_fail++;
                $display("FAIL event: got %s t=%0d pix=%0d, required %s t=%0d pix=%0d",
                         k.name(), cyc, bus.PIX_IDX, e.kind.name(), e.t, e.pix);
            end
        end
    endtask

    // Reference timeline of one scan; START is sampled on the edge ending cycle s.
    task automatic model_scan(input int s, input int npix, input int ninj, input int gd,
                              input int per, input int tmo, input int adly, input int blen);
        int t, g, first, ni, pe, d, dl, tt, nx;
        if (npix == 0) begin
            exp_q.push_back('{EV_DONE, s + 1, -1});
            return;
        end
        exp_tmo = 1'b0;
        ni = (ninj < 1) ? 1 : ninj;
        pe = (per < 2) ? 2 : per;
        tt = (tmo < 1) ? 1 : tmo;
        t  = s + 1;
        nx = t;
        for (int p = 0; p < npix; p++) begin
            exp_q.push_back('{EV_CONF, t, p});
            g = t + ((adly < 1) ? 1 : adly);
            exp_q.push_back('{EV_GRISE, g, p});
            first = g + ((gd < 1) ? 1 : gd);
            for (int k = 0; k < ni; k++) exp_q.push_back('{EV_INJ, first + k * pe, p});
            d = first + ni * pe;
            exp_q.push_back('{EV_GFALL, d, p});
            if (blen < tt) dl = blen + 1;
            else begin
                dl = tt;
                exp_tmo = 1'b1;
            end
            nx = d + dl;
            t  = nx + 1;
        end
        exp_q.push_back('{EV_DONE, nx + 1, npix - 1});
    endtask

    // Configuration-ack responder and readout-busy emulation.
    initial begin
        int  rcnt = 0;
        int  dcnt = 1000000;
        logic g_prev = 1'b0;
        bus.CONF_ACK = 1'b0;
        bus.RO_BUSY  = 1'b0;
        forever begin
            @(negedge CLK40);
            if (bus.CONF_REQ) begin
                rcnt++;
                bus.CONF_ACK = (rcnt >= ack_dly);
            end else begin
                rcnt = 0;
                bus.CONF_ACK = 1'b0;
            end
            if (g_prev && !bus.GATE) dcnt = 0;
            else if (dcnt < 1000000) dcnt++;
            bus.RO_BUSY = (dcnt < busy_len);
            g_prev = bus.GATE;
        end
    end

    // Monitor: every observed event is popped from the scoreboard and compared.
    initial begin
        logic gate_prev = 1'b0;
        logic req_prev  = 1'b0;
        forever begin
            @(negedge CLK40);
            if (mon_en) begin
                if (bus.CONF_REQ && !req_prev) check_ev(EV_CONF);
                if (bus.GATE && !gate_prev)    check_ev(EV_GRISE);
                if (bus.INJ)                   check_ev(EV_INJ);
                if (!bus.GATE && gate_prev)    check_ev(EV_GFALL);
                if (bus.DONE)                  check_ev(EV_DONE);
            end
            if (bus.GATE) check_val("conf_req_during_gate", bus.CONF_REQ, 0);
`ifdef INJ_SCAN_SEQ_GRAY_RST_EN
            check_val("rst_gray", bus.RST_GRAY, (bus.GATE && !gate_prev) ? 1 : 0);
`else
            check_val("rst_gray", bus.RST_GRAY, 0);
`endif
            req_prev  = bus.CONF_REQ;
            gate_prev = bus.GATE;
        end
    end

    task automatic run_scan(input int npix, input int ninj, input int gd, input int per,
                            input int tmo, input int adly, input int blen, input bit restart);
        int budget;
        ack_dly        = adly;
        busy_len       = blen;
        bus.N_PIX      = 8'(npix);
        bus.N_INJ      = 16'(ninj);
        bus.GATE_DLY   = 16'(gd);
        bus.INJ_PERIOD = 16'(per);
        bus.DRAIN_TMO  = 16'(tmo);
        @(negedge CLK40);
        model_scan(cyc, npix, ninj, gd, per, tmo, adly, blen);
        bus.START = 1'b1;
        @(negedge CLK40);
        bus.START      = 1'b0;
        bus.N_PIX      = 8'($urandom);
        bus.N_INJ      = 16'($urandom);
        bus.GATE_DLY   = 16'($urandom);
        bus.INJ_PERIOD = 16'($urandom);
        bus.DRAIN_TMO  = 16'($urandom);
        if (restart && (npix != 0)) begin
            @(negedge CLK40);
            bus.START = 1'b1;
            @(negedge CLK40);
            bus.START = 1'b0;
        end
        budget = 0;
        while ((exp_q.size() != 0) && (budget < 5000)) begin
            @(negedge CLK40);
            budget++;
        end
        if (exp_q.size() != 0) begin
            check_val("scan_timeout_pending_events", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge CLK40);
        check_val("tmo_err_after_scan", bus.TMO_ERR, exp_tmo);
        check_val("busy_after_scan", bus.BUSY, 0);
    endtask

    initial begin
        int cnt, b, dsum;
        int npix, ninj, gd, per, tmo, adly, blen;
        bus.START      = 1'b0;
        bus.ABORT      = 1'b0;
        bus.N_PIX      = '0;
        bus.N_INJ      = '0;
        bus.GATE_DLY   = '0;
        bus.INJ_PERIOD = '0;
        bus.DRAIN_TMO  = '0;

        repeat (2) @(negedge CLK40);
        check_val("rst_busy", bus.BUSY, 0);
        check_val("rst_gate", bus.GATE, 0);
        check_val("rst_inj", bus.INJ, 0);
        check_val("rst_conf_req", bus.CONF_REQ, 0);
        check_val("rst_done", bus.DONE, 0);
        check_val("rst_tmo_err", bus.TMO_ERR, 0);
        check_val("rst_pix_idx", bus.PIX_IDX, 0);
        check_val("rst_rst_gray", bus.RST_GRAY, 0);
        #2 nRST = 1'b1;
        @(negedge CLK40);
        mon_en = 1'b1;

        run_scan(2, 3, 4, 10, 5, 1, 0, 0);
        run_scan(1, 2, 2, 3, 5, 7, 0, 0);
        run_scan(2, 1, 1, 2, 20, 1, 1000, 0);
        run_scan(1, 1, 0, 2, 5, 1, 0, 0);
        run_scan(0, 2, 2, 2, 2, 1, 0, 0);
        run_scan(2, 0, 1, 1, 3, 1, 0, 0);
        run_scan(1, 3, 2, 1, 6, 2, 2, 1);

        // Abort in the PERIOD following the second injection.
        mon_en = 1'b0;
        exp_q.delete();
        ack_dly = 1; busy_len = 0;
        bus.N_PIX = 8'd2; bus.N_INJ = 16'd3; bus.GATE_DLY = 16'd2;
        bus.INJ_PERIOD = 16'd5; bus.DRAIN_TMO = 16'd4;
        @(negedge CLK40);
        bus.START = 1'b1;
        @(negedge CLK40);
        bus.START = 1'b0;
        cnt = 0; b = 0;
        while ((cnt < 2) && (b < 200)) begin
            @(negedge CLK40);
            b++;
            if (bus.INJ) cnt++;
        end
        check_val("abort_inj_seen", cnt, 2);
        @(negedge CLK40);
        check_val("abort_pre_gate", bus.GATE, 1);
        bus.ABORT = 1'b1;
        @(negedge CLK40);
        bus.ABORT = 1'b0;
        check_val("abort_busy", bus.BUSY, 0);
        check_val("abort_gate", bus.GATE, 0);
        check_val("abort_inj", bus.INJ, 0);
        check_val("abort_conf_req", bus.CONF_REQ, 0);
        dsum = 0;
        repeat (10) begin
            @(negedge CLK40);
            dsum += int'(bus.DONE);
        end
        check_val("abort_no_done", dsum, 0);
        bus.START = 1'b1;
        bus.ABORT = 1'b1;
        @(negedge CLK40);
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        check_val("start_abort_busy", bus.BUSY, 0);
        check_val("start_abort_done", bus.DONE, 0);
        mon_en = 1'b1;
        run_scan(2, 2, 1, 3, 4, 1, 0, 0);

        // Reset pulse while INJ is high.
        mon_en = 1'b0;
        bus.N_PIX = 8'd2; bus.N_INJ = 16'd3; bus.GATE_DLY = 16'd1;
        bus.INJ_PERIOD = 16'd4; bus.DRAIN_TMO = 16'd4;
        @(negedge CLK40);
        bus.START = 1'b1;
        @(negedge CLK40);
        bus.START = 1'b0;
        b = 0;
        while (!bus.INJ && (b < 200)) begin
            @(negedge CLK40);
            b++;
        end
        check_val("reset_pre_inj", bus.INJ, 1);
        #2 nRST = 1'b0;
        #1;
        check_val("reset_async_inj", bus.INJ, 0);
        check_val("reset_async_gate", bus.GATE, 0);
        @(negedge CLK40);
        #2 nRST = 1'b1;
        dsum = 0;
        repeat (5) begin
            @(negedge CLK40);
            dsum += int'(bus.DONE) + int'(bus.BUSY);
        end
        check_val("reset_release_idle", dsum, 0);
        check_val("reset_pix_idx", bus.PIX_IDX, 0);
        exp_q.delete();
        exp_tmo = 1'b0;
        mon_en  = 1'b1;
        run_scan(1, 2, 3, 2, 3, 2, 0, 0);

        for (int i = 0; i < 20; i++) begin
            npix = $urandom_range(0, 3);
            ninj = $urandom_range(0, 3);
            gd   = $urandom_range(0, 5);
            per  = $urandom_range(0, 6);
            tmo  = $urandom_range(0, 6);
            adly = $urandom_range(1, 4);
            case ($urandom_range(0, 3))
                0:       blen = 0;
                1:       blen = 1;
                2:       blen = 3;
                default: blen = 1000;
            endcase
            run_scan(npix, ninj, gd, per, tmo, adly, blen, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inj_scan_seq.md
INJ_SCAN_SEQ -- requirements
Module: inj_scan_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of all timing and repeat counters.
REQ-002 SHALL have parameter PIX_W, default 8: width of the pixel index.
REQ-003 SHALL have port CLK40  in  1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port nRST  in  1: reset, asynchronous and active-low.
REQ-005 SHALL have port START  in  1: one-cycle scan start request.
REQ-006 SHALL have port ABORT  in  1: level; aborts a running scan.
REQ-007 SHALL have port N_PIX  in  PIX_W: number of pixels to scan; 0 means no scan.
REQ-008 SHALL have port N_INJ  in  CNT_W: injections per pixel; 0 is treated as 1.
REQ-009 SHALL have port GATE_DLY  in  CNT_W: cycles from GATE rise to INJ.
REQ-010 SHALL have port INJ_PERIOD  in  CNT_W: cycles between injection starts; minimum 2.
REQ-011 SHALL have port DRAIN_TMO  in  CNT_W: cycle limit for RO_BUSY to clear.
REQ-012 SHALL have port CONF_REQ  out  1: request to load the configuration for PIX_IDX.
REQ-013 SHALL have port CONF_ACK  in  1: configuration load done.
REQ-014 SHALL have port RO_BUSY  in  1: readout FIFO non-empty or token active.
REQ-015 SHALL have port PIX_IDX  out  PIX_W: current pixel.
REQ-016 SHALL have port GATE  out  1: TDC/timestamp gate.
REQ-017 SHALL have port INJ  out  1: one-cycle injection pulse.
REQ-018 SHALL have port RST_GRAY  out  1: gray-counter reset pulse.
REQ-019 SHALL have port BUSY  out  1: high whenever the FSM is not in IDLE.
REQ-020 SHALL have port DONE  out  1: one-cycle pulse at scan end.
REQ-021 SHALL have port TMO_ERR  out  1: sticky drain-timeout flag.

Function
REQ-022 SHALL implement the states IDLE, CONF, GATE_WAIT, INJECT, PERIOD, DRAIN and NEXT.
REQ-023 IDLE: START with N_PIX!=0 SHALL latch all parameters, clear PIX_IDX and TMO_ERR, and go to CONF on the next cycle. START with N_PIX==0 SHALL pulse DONE only.
REQ-024 CONF: CONF_REQ SHALL be held high until CONF_ACK is sampled high. The FSM SHALL go to GATE_WAIT on the cycle after the ACK, and CONF_REQ SHALL be low in that cycle.
REQ-025 GATE_WAIT: GATE SHALL rise on entry. After exactly GATE_DLY cycles (0 means next cycle) the FSM SHALL go to INJECT.
REQ-026 INJECT: INJ SHALL be high for exactly 1 cycle and the injection counter SHALL increment. The FSM SHALL then go to PERIOD.
REQ-027 PERIOD: the FSM SHALL wait until INJ_PERIOD cycles after the INJ cycle. If the count is below N_INJ, the FSM SHALL go to INJECT; otherwise it SHALL drop GATE and go to DRAIN.
REQ-028 DRAIN: the FSM SHALL exit to NEXT on the first cycle RO_BUSY is low. If RO_BUSY stays high for DRAIN_TMO cycles, the FSM SHALL set TMO_ERR and go to NEXT anyway.
REQ-029 NEXT: if PIX_IDX==N_PIX-1, the FSM SHALL pulse DONE and go to IDLE. Otherwise PIX_IDX SHALL increment (no wrap), the injection counter SHALL clear, and the FSM SHALL go to CONF.
REQ-030 GATE SHALL be high continuously from GATE_WAIT entry through the last PERIOD cycle.
REQ-031 ABORT in any non-IDLE state SHALL return the FSM to IDLE on the next cycle, drop GATE, INJ and CONF_REQ, and not pulse DONE.
REQ-032 START while BUSY SHALL be ignored. If START and ABORT occur together in IDLE, ABORT SHALL win.
REQ-033 INJ_PERIOD values below 2 SHALL be clamped to 2. Counters SHALL saturate and never wrap.

Reset
REQ-034 While nRST is low, the FSM SHALL be in IDLE and every output and counter SHALL be 0.
REQ-035 Reset asserted mid-scan SHALL drop GATE and INJ immediately (asynchronously) and produce no DONE.

Configuration
REQ-036 With the macro INJ_SCAN_SEQ_GRAY_RST_EN defined, RST_GRAY SHALL pulse high for 1 cycle on the GATE_WAIT entry cycle.
REQ-037 Without INJ_SCAN_SEQ_GRAY_RST_EN, RST_GRAY SHALL be a constant 0 and the related logic SHALL be absent.

Structure
REQ-038 A shared package inj_scan_pkg SHALL hold the state enumeration, the INJ_PERIOD minimum constant (2) and the default widths.
REQ-039 One sub-module, seq_timer, SHALL provide a loadable saturating down-counter with a zero flag, shared by GATE_WAIT, PERIOD and DRAIN.

Verification
REQ-040 N_PIX=2, N_INJ=3, GATE_DLY=4, INJ_PERIOD=10, immediate CONF_ACK, RO_BUSY=0 -> 6 INJ pulses, 10 cycles apart within each pixel; first INJ 4 cycles after GATE rise; PIX_IDX 0 then 1; one DONE.
REQ-041 CONF_ACK delayed 7 cycles -> CONF_REQ high for 7 cycles; GATE stays low until the cycle after the ACK.
REQ-042 RO_BUSY held high, DRAIN_TMO=20 -> NEXT entered 20 cycles after GATE falls; TMO_ERR=1 and stays set until the next START.
REQ-043 ABORT asserted during the 2nd PERIOD -> IDLE next cycle; GATE=0; no DONE; a following START runs a clean scan from PIX_IDX=0.
REQ-044 nRST pulsed low during INJECT -> INJ and GATE go to 0 immediately; BUSY=0 after release.
REQ-045 Edge cases: N_PIX=0 -> DONE only, no GATE; N_INJ=0 -> 1 injection per pixel; INJ_PERIOD=1 -> INJ pulses 2 cycles apart.
